// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster timing generator.
// Defaults describe standard 640x480@60 with a 2:1 pixel clock divide.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_CNT_W    = 10;
  localparam int DEF_ADDR_W   = 19;

  // Registered per-pixel flags that travel together with hcount/vcount.
  typedef struct packed {
    logic pixel_strobe;
    logic line_start;
    logic frame_start;
    logic active;
    logic hsync;
    logic vsync;
  } vga_flags_t;

  // Total pixels per line from its four regions.
  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Total lines per frame from its four regions.
  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Number of bits needed to hold values 0..max_val (at least one bit).
  function automatic int bits_for(int max_val);
    if (max_val <= 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel
// fetch / output stage. The generator is the master; the consumer drives
// only the run/freeze enable.
interface vga_timing_gen_if #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 19
);

  logic              enable;
  logic              pixel_strobe;
  logic [CNT_W-1:0]  hcount;
  logic [CNT_W-1:0]  vcount;
  logic              hsync;
  logic              vsync;
  logic              active;
  logic              line_start;
  logic              frame_start;
  logic [ADDR_W-1:0] addr;

  modport master (
    input  enable,
    output pixel_strobe, hcount, vcount, hsync, vsync,
    output active, line_start, frame_start, addr
  );

  modport slave (
    output enable,
    input  pixel_strobe, hcount, vcount, hsync, vsync,
    input  active, line_start, frame_start, addr
  );

endinterface

// File: rtl/vga_timing_gen_pixel_strobe_gen.sv
// Pixel clock divider: counts clk cycles while enabled and raises a
// combinational advance pulse on the last cycle of each pixel period.
// The phase is frozen while enable is low so a paused raster resumes
// exactly where it stopped.
module pixel_strobe_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  output logic advance
);

  localparam int DIV_W = bits_for(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider phase: wraps at CLK_DIV-1, holds while disabled.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign advance = enable && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Optional feature macro: VGA_TIMING_ADDR_EN enables the linear framebuffer
// address counter; without it the addr output is tied to zero.
// All outputs are registered and decoded from the next-count values so that
// sync, blanking, markers and address line up with hcount/vcount.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic clk,
  input  logic n_rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Reset parks the raster on the last back-porch pixel of the frame so the
  // first advance lands on (0,0).
  localparam vga_flags_t FLAGS_RST = '{
    pixel_strobe: 1'b0,
    line_start:   1'b0,
    frame_start:  1'b0,
    active:       1'b0,
    hsync:        ~HSYNC_POL,
    vsync:        ~VSYNC_POL
  };

  // Reject configurations whose counters or address cannot be represented.
  if (bits_for(H_TOTAL - 1) > CNT_W) begin : g_err_hcnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1");
  end
  if (bits_for(V_TOTAL - 1) > CNT_W) begin : g_err_vcnt_w
    $error("vga_timing_gen: CNT_W too narrow for V_TOTAL-1");
  end
  if (bits_for(H_ACTIVE * V_ACTIVE - 1) > ADDR_W) begin : g_err_addr_w
    $error("vga_timing_gen: ADDR_W too narrow for H_ACTIVE*V_ACTIVE-1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 ||
      V_BP < 1 || CLK_DIV < 1) begin : g_err_regions
    $error("vga_timing_gen: porches, sync widths and CLK_DIV must be >= 1");
  end

  logic             advance;
  logic [CNT_W-1:0] hcount_q;
  logic [CNT_W-1:0] vcount_q;
  vga_flags_t       flags_q;

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             origin_next;
  logic             active_next;
  logic             hsync_next;
  logic             vsync_next;

  pixel_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .clk     (clk),
    .n_rst   (n_rst),
    .enable  (vga.enable),
    .advance (advance)
  );

  // Next raster position and the levels that describe it.
  always_comb begin
    h_wrap      = (hcount_q == H_LAST);
    h_next      = h_wrap ? '0 : hcount_q + CNT_W'(1);
    v_next      = vcount_q;
    if (h_wrap) begin
      v_next = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
    end
    origin_next = (h_next == '0) && (v_next == '0);
    active_next = (h_next < H_VIS) && (v_next < V_VIS);
    hsync_next  = ((h_next >= HS_START) && (h_next < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next  = ((v_next >= VS_START) && (v_next < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Position and flag registers; pulses only on advance, levels hold otherwise.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      flags_q  <= FLAGS_RST;
    end else begin
      flags_q.pixel_strobe <= advance;
      flags_q.line_start   <= advance && (h_next == '0);
      flags_q.frame_start  <= advance && origin_next;
      if (advance) begin
        hcount_q       <= h_next;
        vcount_q       <= v_next;
        flags_q.active <= active_next;
        flags_q.hsync  <= hsync_next;
        flags_q.vsync  <= vsync_next;
      end
    end
  end

`ifdef VGA_TIMING_ADDR_EN
  logic [ADDR_W-1:0] addr_q;

  // Linear address: restarts at the frame origin, steps into each active
  // pixel after it, and holds through blanking.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= '0;
    end else if (advance) begin
      if (origin_next) begin
        addr_q <= '0;
      end else if (active_next) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign vga.addr = addr_q;
`else
  assign vga.addr = '0;
`endif

  assign vga.pixel_strobe = flags_q.pixel_strobe;
  assign vga.line_start   = flags_q.line_start;
  assign vga.frame_start  = flags_q.frame_start;
  assign vga.active       = flags_q.active;
  assign vga.hsync        = flags_q.hsync;
  assign vga.vsync        = flags_q.vsync;
  assign vga.hcount       = hcount_q;
  assign vga.vcount       = vcount_q;

endmodule
